// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings, widths and small decode helpers for the memory-access stage.
// Imported by the stage top and its load alignment unit.
package mem_stage_lsu_pkg;

    localparam int REG_W          = 32;
    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [REG_W-1:0]          ZERO_WORD = '0;
    localparam logic [REG_ADDR_W_DEF-1:0] ZERO_REG  = '0;

    typedef enum logic [3:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LB   = 4'd1,
        MEMOP_LH   = 4'd2,
        MEMOP_LW   = 4'd3,
        MEMOP_LBU  = 4'd4,
        MEMOP_LHU  = 4'd5,
        MEMOP_SB   = 4'd6,
        MEMOP_SH   = 4'd7,
        MEMOP_SW   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_ISSUE = 2'd1,
        ST_LOAD_TAIL  = 2'd2,
        ST_STORE      = 2'd3
    } lsu_state_e;

    function automatic logic is_load(input logic [3:0] op);
        case (op)
            MEMOP_LB, MEMOP_LH, MEMOP_LW, MEMOP_LBU, MEMOP_LHU: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        case (op)
            MEMOP_SB, MEMOP_SH, MEMOP_SW: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // Index of the last byte of the access (access length minus one).
    function automatic logic [1:0] last_byte(input logic [3:0] op);
        case (op)
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: return 2'd1;
            MEMOP_LW, MEMOP_SW:            return 2'd3;
            default:                       return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load result assembly: little-endian byte gather with
// sign or zero extension selected by the load opcode.
module mem_stage_lsu_load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [3:0]       memop,
    input  logic [3:0][7:0]  bytes,
    output logic [REG_W-1:0] value
);

    // NOTE: every output of an always_comb gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        value = ZERO_WORD;
        case (memop)
            MEMOP_LB:  value = {{24{bytes[0][7]}}, bytes[0]};
            MEMOP_LBU: value = {24'd0, bytes[0]};
            MEMOP_LH:  value = {{16{bytes[1][7]}}, bytes[1], bytes[0]};
            MEMOP_LHU: value = {16'd0, bytes[1], bytes[0]};
            MEMOP_LW:  value = bytes;
            default:   value = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: byte-serial loads/stores over an 8-bit RAM port and
// registered writeback of ALU and load results; stalls EX while busy.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [3:0]            ex_memop,
    input  logic [ADDR_W-1:0]     ex_addr,
    input  logic [REG_W-1:0]      ex_result,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_wreg,

    output logic                  wb_write_enable,
    output logic [REG_ADDR_W-1:0] wb_write_address,
    output logic [REG_W-1:0]      wb_write_value,

    output logic [ADDR_W-1:0]     mem_a,
    output logic                  mem_wr,
    output logic [7:0]            mem_dout,
    input  logic [7:0]            mem_din
);

    lsu_state_e            state_q, state_d;

    logic [3:0]            op_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [3:0][7:0]       data_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  wreg_q;
    logic [1:0]            idx_q;
    logic [1:0]            last_q;
    logic [3:0][7:0]       bytes_q;
    logic [3:0][7:0]       bytes_merged;
    logic [REG_W-1:0]      load_value;

    logic                  accept;
    logic                  accept_none;
    logic                  rd_writes;
    logic                  rd_q_writes;

    assign accept      = ex_valid && ex_ready;
    assign accept_none = accept && !is_load(ex_memop) && !is_store(ex_memop);
    assign rd_writes   = ex_wreg && (ex_rd != REG_ADDR_W'(ZERO_REG));
    assign rd_q_writes = wreg_q && (rd_q != REG_ADDR_W'(ZERO_REG));

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_load(ex_memop)) begin
                    state_d = ST_LOAD_ISSUE;
                end else if (accept && is_store(ex_memop)) begin
                    state_d = ST_STORE;
                end
            end
            ST_LOAD_ISSUE: begin
                if (idx_q == last_q) begin
                    state_d = ST_LOAD_TAIL;
                end
            end
            ST_LOAD_TAIL: state_d = ST_IDLE;
            ST_STORE: begin
                if (idx_q == last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM port and handshake are decoded from state alone, so an asynchronous
    // reset drops an in-flight store off the bus immediately.
    always_comb begin
        ex_ready = 1'b0;
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = 8'd0;
        case (state_q)
            ST_IDLE:       ex_ready = 1'b1;
            ST_LOAD_ISSUE: mem_a = addr_q;
            ST_LOAD_TAIL:  mem_a = '0;
            ST_STORE: begin
                mem_wr   = 1'b1;
                mem_a    = addr_q;
                mem_dout = data_q[idx_q];
            end
            default: ex_ready = 1'b0;
        endcase
    end

    // NOTE: datapath registers are reset as well, so nothing downstream can
    // observe X values even though only the FSM strictly needs a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
            rd_q    <= '0;
            wreg_q  <= 1'b0;
            idx_q   <= 2'd0;
            last_q  <= 2'd0;
            bytes_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q    <= ex_memop;
                        addr_q  <= ex_addr;
                        data_q  <= ex_result;
                        rd_q    <= ex_rd;
                        wreg_q  <= ex_wreg;
                        idx_q   <= 2'd0;
                        last_q  <= last_byte(ex_memop);
                        bytes_q <= '0;
                    end
                end
                ST_LOAD_ISSUE: begin
                    // Read data lags its address by one cycle.
                    if (idx_q != 2'd0) begin
                        bytes_q[idx_q - 2'd1] <= mem_din;
                    end
                    addr_q <= addr_q + ADDR_W'(1);
                    if (idx_q != last_q) begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                ST_LOAD_TAIL: bytes_q[idx_q] <= mem_din;
                ST_STORE: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    idx_q  <= idx_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // The final byte arrives in the same cycle the writeback is registered.
    always_comb begin
        bytes_merged        = bytes_q;
        bytes_merged[idx_q] = mem_din;
    end

    mem_stage_lsu_load_align u_load_align (
        .memop (op_q),
        .bytes (bytes_merged),
        .value (load_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_write_enable  <= 1'b0;
            wb_write_address <= '0;
            wb_write_value   <= ZERO_WORD;
        end else begin
            wb_write_enable <= 1'b0;
            if (accept_none) begin
                wb_write_enable  <= rd_writes;
                wb_write_address <= ex_rd;
                wb_write_value   <= ex_result;
            end else if (state_q == ST_LOAD_TAIL) begin
                wb_write_enable  <= rd_q_writes;
                wb_write_address <= rd_q;
                wb_write_value   <= load_value;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a transaction-level model schedules
// expected per-cycle outputs, and one compare process checks them every cycle.
module tb_mem_stage_lsu;

    localparam int ADDR_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int EXP_DEPTH  = 8192;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  ex_valid;
    logic                  ex_ready;
    logic [3:0]            ex_memop;
    logic [ADDR_W-1:0]     ex_addr;
    logic [31:0]           ex_result;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_wreg;
    logic                  wb_write_enable;
    logic [REG_ADDR_W-1:0] wb_write_address;
    logic [31:0]           wb_write_value;
    logic [ADDR_W-1:0]     mem_a;
    logic                  mem_wr;
    logic [7:0]            mem_dout;
    logic [7:0]            mem_din;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_ready         (ex_ready),
        .ex_memop         (ex_memop),
        .ex_addr          (ex_addr),
        .ex_result        (ex_result),
        .ex_rd            (ex_rd),
        .ex_wreg          (ex_wreg),
        .wb_write_enable  (wb_write_enable),
        .wb_write_address (wb_write_address),
        .wb_write_value   (wb_write_value),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .mem_dout         (mem_dout),
        .mem_din          (mem_din)
    );

    // RAM environment: 256 bytes aliased on the low address bits.
    logic [7:0] ram_init [256];
    logic [7:0] ram      [256];
    bit         written  [256];
    logic [7:0] shadow   [256];

    function automatic logic [7:0] ram_rd(input logic [7:0] a);
        return written[a] ? ram[a] : ram_init[a];
    endfunction

    always @(posedge clk) begin
        if (mem_wr === 1'b1) begin
            ram[mem_a[7:0]]     <= mem_dout;
            written[mem_a[7:0]] <= 1'b1;
        end
        mem_din <= ram_rd(mem_a[7:0]);
    end

    int vectors     = 0;
    int miscompares = 0;
    int edge_n;

    always @(posedge clk or negedge rst) begin
        if (!rst) edge_n <= 0;
        else      edge_n <= edge_n + 1;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, actual, expected, edge_n);
        end
    endtask

    // Expected outputs for the interval that follows edge k.
    typedef struct {
        bit          ready;
        bit          wr;
        bit          a_chk;
        logic [31:0] a;
        bit          dout_chk;
        logic [7:0]  dout;
        bit          wb;
        logic [4:0]  wa;
        logic [31:0] wv;
    } exp_t;

    exp_t exp_at [EXP_DEPTH];
    exp_t e_cur;
    bit   chk_en = 1'b0;
    int   wb_cnt = 0;
    logic [31:0] last_wb_val  = '0;
    logic [4:0]  last_wb_addr = '0;

    always @(negedge clk) begin
        if (chk_en && rst === 1'b1) begin
            e_cur = exp_at[edge_n];
            check("ex_ready", 32'(ex_ready), 32'(e_cur.ready));
            check("mem_wr", 32'(mem_wr), 32'(e_cur.wr));
            if (e_cur.a_chk)    check("mem_a", mem_a, e_cur.a);
            if (e_cur.dout_chk) check("mem_dout", 32'(mem_dout), 32'(e_cur.dout));
            check("wb_enable", 32'(wb_write_enable), 32'(e_cur.wb));
            if (e_cur.wb) begin
                check("wb_address", 32'(wb_write_address), 32'(e_cur.wa));
                check("wb_value", wb_write_value, e_cur.wv);
            end
            if (wb_write_enable === 1'b1) begin
                wb_cnt++;
                last_wb_val  = wb_write_value;
                last_wb_addr = wb_write_address;
            end
        end
    end

    int free_edge = 0;

    // Behavioural model: from the accept edge t, lay out the expected
    // bus and writeback activity for every following cycle.
    task automatic schedule(input int t, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] res, input logic [4:0] rd, input bit wreg);
        int n;
        bit ld, st, sgn;
        logic [31:0] v;
        n = 0; ld = 0; st = 0; sgn = 0;
        case (op)
            4'd1: begin n = 1; ld = 1; sgn = 1; end
            4'd2: begin n = 2; ld = 1; sgn = 1; end
            4'd3: begin n = 4; ld = 1; end
            4'd4: begin n = 1; ld = 1; end
            4'd5: begin n = 2; ld = 1; end
            4'd6: begin n = 1; st = 1; end
            4'd7: begin n = 2; st = 1; end
            4'd8: begin n = 4; st = 1; end
            default: ;
        endcase
        if (ld) begin
            v = 0;
            for (int i = 0; i < n; i++) begin
                exp_at[t+i].ready    = 0;
                exp_at[t+i].a        = addr + 32'(i);
                exp_at[t+i].dout_chk = 0;
                v = v | (32'(shadow[8'(addr + 32'(i))]) << (8 * i));
            end
            exp_at[t+n].ready    = 0;
            exp_at[t+n].a_chk    = 0;
            exp_at[t+n].dout_chk = 0;
            if (sgn && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            exp_at[t+n+1].wb = wreg && (rd != 0);
            exp_at[t+n+1].wa = rd;
            exp_at[t+n+1].wv = v;
            free_edge = t + n + 2;
        end else if (st) begin
            for (int i = 0; i < n; i++) begin
                exp_at[t+i].ready = 0;
                exp_at[t+i].wr    = 1;
                exp_at[t+i].a     = addr + 32'(i);
                exp_at[t+i].dout  = res[8*i +: 8];
                shadow[8'(addr + 32'(i))] = res[8*i +: 8];
            end
            free_edge = t + n + 1;
        end else begin
            exp_at[t].wb = wreg && (rd != 0);
            exp_at[t].wa = rd;
            exp_at[t].wv = res;
            free_edge = t + 1;
        end
    endtask

    task automatic put_garbage(input bit valid);
        ex_valid  = valid;
        ex_memop  = 4'($urandom_range(0, 15));
        ex_addr   = $urandom;
        ex_result = $urandom;
        ex_rd     = 5'($urandom_range(0, 31));
        ex_wreg   = 1'($urandom_range(0, 1));
    endtask

    // Waits until the model says the stage is free, offering ignored
    // requests meanwhile, then presents the instruction for one edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] res,
                         input logic [4:0] rd, input bit wreg);
        forever begin
            @(negedge clk);
            if (edge_n + 1 >= free_edge) break;
            put_garbage(1'($urandom_range(0, 1)));
        end
        ex_valid  = 1'b1;
        ex_memop  = op;
        ex_addr   = addr;
        ex_result = res;
        ex_rd     = rd;
        ex_wreg   = wreg;
        schedule(edge_n + 1, op, addr, res, rd, wreg);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            put_garbage(1'b0);
        end
    endtask

    task automatic drain();
        while (edge_n < free_edge + 1) begin
            @(negedge clk);
            put_garbage(1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int          wb_before;
    logic [31:0] rnd_addr;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_init[i] = 8'($urandom);
            exp_at[i]   = '{ready: 1, wr: 0, a_chk: 1, a: 0, dout_chk: 1, dout: 0, wb: 0, wa: 0, wv: 0};
        end
        for (int i = 256; i < EXP_DEPTH; i++)
            exp_at[i] = '{ready: 1, wr: 0, a_chk: 1, a: 0, dout_chk: 1, dout: 0, wb: 0, wa: 0, wv: 0};
        ram_init[8'h00] = 8'h78; ram_init[8'h01] = 8'h56;
        ram_init[8'h02] = 8'h34; ram_init[8'h03] = 8'h12;
        ram_init[8'h10] = 8'h80;
        ram_init[8'h20] = 8'h00; ram_init[8'h21] = 8'h80;
        for (int i = 0; i < 256; i++) shadow[i] = ram_init[i];
        put_garbage(1'b0);

        repeat (3) @(negedge clk);
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_wb_enable", 32'(wb_write_enable), 32'd0);
        check("rst_wb_value", wb_write_value, 32'd0);
        rst    = 1'b1;
        chk_en = 1'b1;

        // ALU results, including a reserved code and rd=0.
        issue(4'd0, 32'h0, 32'h1234_5678, 5'd5, 1'b1);
        drain();
        check("none_lit_addr", 32'(last_wb_addr), 32'd5);
        check("none_lit_value", last_wb_val, 32'h1234_5678);
        wb_before = wb_cnt;
        issue(4'd0, 32'h0, 32'h0BAD_F00D, 5'd6, 1'b1);
        issue(4'd0, 32'h0, 32'h5555_AAAA, 5'd0, 1'b1);
        issue(4'd0, 32'h0, 32'h7777_7777, 5'd8, 1'b0);
        issue(4'd12, 32'h0, 32'hCAFE_0001, 5'd9, 1'b1);
        drain();
        check("none_b2b_pulses", 32'(wb_cnt - wb_before), 32'd2);
        check("none_reserved_value", last_wb_val, 32'hCAFE_0001);

        issue(4'd3, 32'h0000_0100, 32'h0, 5'd7, 1'b1);
        drain();
        check("lw_lit", last_wb_val, 32'h1234_5678);
        issue(4'd1, 32'h0000_0010, 32'h0, 5'd7, 1'b1);
        drain();
        check("lb_lit", last_wb_val, 32'hFFFF_FF80);
        issue(4'd4, 32'h0000_0010, 32'h0, 5'd7, 1'b1);
        drain();
        check("lbu_lit", last_wb_val, 32'h0000_0080);
        issue(4'd2, 32'h0000_0020, 32'h0, 5'd7, 1'b1);
        drain();
        check("lh_lit", last_wb_val, 32'hFFFF_8000);
        issue(4'd5, 32'h0000_0020, 32'h0, 5'd7, 1'b1);
        drain();
        check("lhu_lit", last_wb_val, 32'h0000_8000);

        wb_before = wb_cnt;
        issue(4'd7, 32'h0000_0200, 32'hDEAD_BEEF, 5'd3, 1'b1);
        drain();
        check("sh_no_wb", 32'(wb_cnt - wb_before), 32'd0);
        check("sh_ram0", 32'(ram_rd(8'h00)), 32'h0000_00EF);
        check("sh_ram1", 32'(ram_rd(8'h01)), 32'h0000_00BE);
        check("sh_ram2_untouched", 32'(ram_rd(8'h02)), 32'h0000_0034);

        wb_before = wb_cnt;
        issue(4'd2, 32'hFFFF_FFFF, 32'h0, 5'd0, 1'b1);
        drain();
        check("lh_wrap_no_wb", 32'(wb_cnt - wb_before), 32'd0);

        for (int k = 0; k < 400; k++) begin
            if (free_edge > EXP_DEPTH - 16) break;
            rnd_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom;
            issue(4'($urandom_range(0, 15)), rnd_addr, $urandom,
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end
        drain();

        // Reset in the middle of a word store abandons the remaining bytes.
        chk_en = 1'b0;
        @(negedge clk);
        ex_valid  = 1'b1;
        ex_memop  = 4'd8;
        ex_addr   = 32'h0000_0040;
        ex_result = 32'hA1B2_C3D4;
        ex_rd     = 5'd1;
        ex_wreg   = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        check("sw_byte0_wr", 32'(mem_wr), 32'd1);
        check("sw_byte0_a", mem_a, 32'h0000_0040);
        @(posedge clk);
        #2;
        check("sw_byte1_a", mem_a, 32'h0000_0041);
        rst = 1'b0;
        #1;
        check("async_rst_mem_wr", 32'(mem_wr), 32'd0);
        check("async_rst_mem_a", mem_a, 32'd0);
        check("async_rst_ex_ready", 32'(ex_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_ready", 32'(ex_ready), 32'd1);
            check("post_rst_mem_wr", 32'(mem_wr), 32'd0);
        end
        check("sw_abort_ram40", 32'(ram_rd(8'h40)), 32'h0000_00D4);
        check("sw_abort_ram41", 32'(ram_rd(8'h41)), 32'(shadow[8'h41]));
        check("sw_abort_ram42", 32'(ram_rd(8'h42)), 32'(shadow[8'h42]));
        check("sw_abort_ram43", 32'(ram_rd(8'h43)), 32'(shadow[8'h43]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage directly upstream of the register file write port.
- Takes one instruction per handshake from EX and runs byte-serial loads and stores over the 8-bit RAM port.
- Drives the register file's write_enable / write_address / write_value for both ALU results and load results.
- Holds ex_ready low while a memory access is in flight, which stalls the pipeline.

Parameters:
ADDR_W, 32, RAM byte-address width; address increments wrap modulo 2^ADDR_W
REG_ADDR_W, 5, register index width (matches register file)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
ex_valid  in  1  EX presents an instruction
ex_ready  out  1  stage can accept; transfer occurs when ex_valid & ex_ready at a rising edge
ex_memop  in  4  0=NONE 1=LB 2=LH 3=LW 4=LBU 5=LHU 6=SB 7=SH 8=SW; codes 9-15 treated as NONE
ex_addr  in  ADDR_W  effective address (loads/stores)
ex_result  in  32  ALU result (NONE) or store data (stores)
ex_rd  in  REG_ADDR_W  destination register
ex_wreg  in  1  instruction writes rd
wb_write_enable  out  1  to register file write_enable
wb_write_address  out  REG_ADDR_W  to register file write_address
wb_write_value  out  32  to register file write_value
mem_a  out  ADDR_W  RAM byte address
mem_wr  out  1  1=write, 0=read
mem_dout  out  8  RAM write byte
mem_din  in  8  RAM read byte; valid exactly one cycle after the address is presented with mem_wr=0

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, all outputs 0 except ex_ready=1. A partially issued store is abandoned and no further RAM writes occur.
- FSM states: IDLE, LOAD_ISSUE, LOAD_TAIL, STORE.
- IDLE: ex_ready=1; mem_a=0, mem_wr=0, mem_dout=0.
- Default pulse: wb_write_enable is a one-cycle registered pulse, 0 unless stated below.
- NONE accepted at edge t:
  - During cycle t+1: wb_write_enable=ex_wreg & (ex_rd!=0), address=ex_rd, value=ex_result.
  - Stays IDLE, so throughput is 1 instruction per cycle.
- Load of N bytes (LB/LBU N=1, LH/LHU N=2, LW N=4) accepted at t:
  - Latch op, addr, rd and wreg; go to LOAD_ISSUE.
  - Cycles t+1..t+N: mem_a=addr+i (i=0..N-1), mem_wr=0.
  - Byte i is captured from mem_din in cycle t+2+i; LOAD_TAIL covers cycle t+N+1, which captures the last byte.
  - Cycle t+N+2: back in IDLE, wb pulse with the assembled value. Load latency = N+2 cycles.
  - ex_ready=0 for cycles t+1..t+N+1.
- Store of N bytes (SB N=1, SH N=2, SW N=4) accepted at t:
  - Cycles t+1..t+N: mem_wr=1, mem_a=addr+i, mem_dout=ex_result[8i+7:8i] (little-endian).
  - Cycle t+N+1: IDLE, ex_ready=1, no writeback.
- Load assembly, little-endian (byte 0 = LSB):
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW takes all 32 bits.
- rd==0 or wreg==0: no wb pulse, but a load still performs all RAM reads.
- Address wrap: addr+i computed modulo 2^ADDR_W, e.g. 0xFFFFFFFF+1 -> 0x00000000.
- ex_valid while ex_ready=0: ignored, not latched; upstream holds its inputs.
- No misalignment check; unaligned addresses are legal because access is byte-serial.
- Byte counter is 2 bits; N−1 is stored at accept.

Decomposition:
- Shared defines file (Defines.v):
  - memop encodings MEMOP_NONE..MEMOP_SW
  - FSM state encodings
  - zeroword, zeroreg
  - regaddrbus / regbus widths
- One sub-module: load_align (combinational), which takes memop and the 4 captured bytes and outputs the extended 32-bit value.

Test Plan:
- NONE, rd=5, wreg=1, ex_result=0x12345678 -> next cycle wb_write_enable=1, addr=5, value=0x12345678; ex_ready stays 1; back-to-back NONEs give a wb pulse every cycle.
- LW addr=0x100, RAM bytes 0x78,0x56,0x34,0x12 -> mem_a=0x100..0x103 on t+1..t+4 with mem_wr=0; wb at t+6 value=0x12345678; ex_ready=0 for t+1..t+5.
- LB on byte 0x80 -> 0xFFFFFF80; LBU on 0x80 -> 0x00000080; LH on bytes 0x00,0x80 -> 0xFFFF8000; LHU -> 0x00008000.
- SH addr=0x200, ex_result=0xDEADBEEF -> t+1: mem_wr=1, a=0x200, dout=0xEF; t+2: a=0x201, dout=0xBE; t+3: mem_wr=0, ex_ready=1; no wb pulse.
- LH addr=0xFFFFFFFF, rd=0 -> mem_a=0xFFFFFFFF then 0x00000000; no wb pulse; ex_ready returns at t+4.
- SW accepted at t, rst driven low mid-cycle t+2 -> mem_wr and mem_a drop to 0 immediately (asynchronously); after release FSM=IDLE, ex_ready=1, no remaining bytes written.
